// File: rtl/dma_snd_pkg.sv
// dma_snd_pkg: shared encodings for the DMA sound playback engine.
// Holds the playback rate codes, the bit positions inside the mode word,
// the sample format enum and helpers for per-strobe FIFO word accounting.
package dma_snd_pkg;

  // mode[1:0] rate codes
  localparam logic [1:0] RATE_6K25 = 2'b00;
  localparam logic [1:0] RATE_12K5 = 2'b01;
  localparam logic [1:0] RATE_25K  = 2'b10;
  localparam logic [1:0] RATE_50K  = 2'b11;

  // mode word bit positions
  localparam int MODE_RATE_LSB  = 0;
  localparam int MODE_MONO_BIT  = 2;
  localparam int MODE_16BIT_BIT = 3;

  // Sample format, encoded as {16-bit, mono} so it maps straight onto mode[3:2]
  typedef enum logic [1:0] {
    FMT_8_STEREO  = 2'b00,
    FMT_8_MONO    = 2'b01,
    FMT_16_STEREO = 2'b10,
    FMT_16_MONO   = 2'b11
  } fmt_e;

  function automatic fmt_e decode_fmt(input logic is16, input logic mono);
    return fmt_e'({is16, mono});
  endfunction

  // Words that must be present for a strobe to be served without underrun.
  function automatic logic [1:0] words_required(input fmt_e fmt);
    return (fmt == FMT_16_STEREO) ? 2'd2 : 2'd1;
  endfunction

  // Words removed from the FIFO by a served strobe. In 8-bit mono the word
  // only leaves once its low byte (bytesel = 1) has been played.
  function automatic logic [1:0] words_popped(input fmt_e fmt, input logic bytesel);
    logic [1:0] n;
    case (fmt)
      FMT_8_STEREO:  n = 2'd1;
      FMT_8_MONO:    n = {1'b0, bytesel};
      FMT_16_STEREO: n = 2'd2;
      FMT_16_MONO:   n = 2'd1;
      default:       n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dma_snd_fifo.sv
// dma_snd_fifo: synchronous 16-bit word FIFO with a level counter so all
// 2^ADDR_BITS slots are usable. Exposes the head and the word behind it
// (peek-2), pops 0/1/2 words per cycle and supports a synchronous flush.
// Ports: clk_i/rst_i (async active-high), flush_i, wr_en_i/wr_dat_i,
//        pop_i (0..2, never more than level_o), head_o, next_o, level_o.
module dma_snd_fifo #(
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 wr_en_i,
  input  logic [15:0]          wr_dat_i,
  input  logic [1:0]           pop_i,
  output logic [15:0]          head_o,
  output logic [15:0]          next_o,
  output logic [ADDR_BITS:0]   level_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS + 1)'(DEPTH);

  logic [15:0]          mem_q [DEPTH];
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_nxt;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic                 wr_ok;

  // A write into a full FIFO still lands when a pop frees a slot on the same
  // edge: with the FIFO full the write slot is the head, which is read
  // combinationally before the edge overwrites it.
  assign wr_ok = wr_en_i & ~flush_i & ((level_q != DEPTH_L) | (pop_i != 2'd0));

  assign rd_nxt  = rd_ptr_q + ADDR_BITS'(1);
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_nxt];
  assign level_o = level_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + ADDR_BITS'(pop_i);
      wr_ptr_d = wr_ptr_q + ADDR_BITS'(wr_ok);
      level_d  = level_q + {{ADDR_BITS{1'b0}}, wr_ok}
                         - {{(ADDR_BITS - 1){1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; words are only observed once counted in level.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/dma_snd_engine.sv
// dma_snd_engine: DMA sound playback engine. Buffers words written on
// SLOAD_N falling edges and plays them out as 8/16-bit, mono/stereo samples
// at 6.25/12.5/25/50 kHz derived from a BASE_DIV divider of clk32.
// Ports: clk32, res (async active-high), enable, mode[3:0], SLOAD_N, MDIN,
//        clr_underrun in; SREQ, fifo_level, underrun, sample_tick,
//        audio_left, audio_right out.
module dma_snd_engine
  import dma_snd_pkg::*;
#(
  parameter int FIFO_ADDR_BITS = 3,   // >= 2
  parameter int BASE_DIV       = 640, // >= 2
  parameter int SREQ_LEVEL     = 1    // 1..2^FIFO_ADDR_BITS
) (
  input  logic                      clk32,
  input  logic                      res,
  input  logic                      enable,
  input  logic [3:0]                mode,
  input  logic                      SLOAD_N,
  input  logic [15:0]               MDIN,
  input  logic                      clr_underrun,
  output logic                      SREQ,
  output logic [FIFO_ADDR_BITS:0]   fifo_level,
  output logic                      underrun,
  output logic                      sample_tick,
  output logic [15:0]               audio_left,
  output logic [15:0]               audio_right
);

  localparam int CNT_W = $clog2(BASE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BASE_DIV - 1);
  localparam logic [FIFO_ADDR_BITS:0] DEPTH_L = (FIFO_ADDR_BITS + 1)'(1 << FIFO_ADDR_BITS);
  localparam logic [FIFO_ADDR_BITS:0] SREQ_L  = (FIFO_ADDR_BITS + 1)'(SREQ_LEVEL);

  // ---------------------------------------------------------------- rate gen
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pre_q, pre_d;
  logic             base_tick;
  logic             rate_hit;
  logic             strobe_q;

  assign base_tick = (cnt_q == '0);
  assign cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  assign pre_d     = base_tick ? pre_q + 3'd1 : pre_q;

  // Decided on the prescaler value present at the base tick, before it steps.
  always_comb begin
    rate_hit = 1'b0;
    case (mode[MODE_RATE_LSB +: 2])
      RATE_50K:  rate_hit = 1'b1;
      RATE_25K:  rate_hit = ~pre_q[0];
      RATE_12K5: rate_hit = (pre_q[1:0] == 2'b00);
      RATE_6K25: rate_hit = (pre_q == 3'b000);
      default:   rate_hit = 1'b0;
    endcase
  end

  // --------------------------------------------------------------- bus write
  logic        sload_q;
  logic        wr_pend_q, wr_pend_d;
  logic [15:0] wr_dat_q, wr_dat_d;

  assign wr_pend_d = sload_q & ~SLOAD_N;
  assign wr_dat_d  = wr_pend_d ? MDIN : wr_dat_q;

  // -------------------------------------------------------------------- FIFO
  logic [15:0]             head, next_w;
  logic [FIFO_ADDR_BITS:0] level;
  logic [1:0]              pop;

  dma_snd_fifo #(
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk_i    (clk32),
    .rst_i    (res),
    .flush_i  (~enable),
    .wr_en_i  (wr_pend_q),
    .wr_dat_i (wr_dat_q),
    .pop_i    (pop),
    .head_o   (head),
    .next_o   (next_w),
    .level_o  (level)
  );

  // ------------------------------------------------------ format / underrun
  fmt_e        fmt;
  logic [1:0]  fmt_bits_q;
  logic        fmt_chg;
  logic [1:0]  need;
  logic        starved;
  logic [7:0]  mono_byte;
  logic        bytesel_q, bytesel_d;
  logic        underrun_q, underrun_d;
  logic        tick_q, tick_d;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;

  assign fmt       = decode_fmt(mode[MODE_16BIT_BIT], mode[MODE_MONO_BIT]);
  assign fmt_chg   = (fmt_bits_q != {mode[MODE_16BIT_BIT], mode[MODE_MONO_BIT]});
  assign need      = words_required(fmt);
  assign starved   = (level < {{(FIFO_ADDR_BITS - 1){1'b0}}, need});
  assign mono_byte = bytesel_q ? head[7:0] : head[15:8];

  always_comb begin
    pop        = 2'd0;
    left_d     = left_q;
    right_d    = right_q;
    bytesel_d  = bytesel_q;
    tick_d     = 1'b0;
    underrun_d = underrun_q & ~clr_underrun;

    if (!enable) begin
      left_d    = '0;
      right_d   = '0;
      bytesel_d = 1'b0;
    end else if (strobe_q) begin
      tick_d = 1'b1;
      if (starved) begin
        // Starved strobe: hold outputs and byte position; set beats clear.
        underrun_d = 1'b1;
      end else begin
        pop = words_popped(fmt, bytesel_q);
        case (fmt)
          FMT_8_STEREO: begin
            left_d  = {head[15:8], 8'h00};
            right_d = {head[7:0], 8'h00};
          end
          FMT_8_MONO: begin
            left_d    = {mono_byte, 8'h00};
            right_d   = {mono_byte, 8'h00};
            bytesel_d = ~bytesel_q;
          end
          FMT_16_STEREO: begin
            left_d  = head;
            right_d = next_w;
          end
          FMT_16_MONO: begin
            left_d  = head;
            right_d = head;
          end
          default: ;
        endcase
      end
    end

    // A format switch realigns mono byte selection to the high byte.
    if (fmt_chg) begin
      bytesel_d = 1'b0;
    end
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      cnt_q      <= '0;
      pre_q      <= '0;
      strobe_q   <= 1'b0;
      sload_q    <= 1'b1;
      wr_pend_q  <= 1'b0;
      wr_dat_q   <= '0;
      fmt_bits_q <= '0;
      bytesel_q  <= 1'b0;
      underrun_q <= 1'b0;
      tick_q     <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      strobe_q   <= base_tick & rate_hit;
      sload_q    <= SLOAD_N;
      wr_pend_q  <= wr_pend_d;
      wr_dat_q   <= wr_dat_d;
      fmt_bits_q <= {mode[MODE_16BIT_BIT], mode[MODE_MONO_BIT]};
      bytesel_q  <= bytesel_d;
      underrun_q <= underrun_d;
      tick_q     <= tick_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  // ----------------------------------------------------------------- outputs
  // SREQ is gated by res as well so the request drops the moment reset is
  // asserted, not only once the level register has cleared.
  assign SREQ        = enable & ~res & ((DEPTH_L - level) >= SREQ_L);
  assign fifo_level  = level;
  assign underrun    = underrun_q;
  assign sample_tick = tick_q;
  assign audio_left  = left_q;
  assign audio_right = right_q;

endmodule

// File: tb/tb_dma_snd_engine.sv
module tb_dma_snd_engine;

  localparam int NB = 3;
  localparam int DIV = 640;

  logic        clk32 = 1'b0;
  logic        res;
  logic        enable;
  logic [3:0]  mode;
  logic        SLOAD_N;
  logic [15:0] MDIN;
  logic        clr_underrun;
  logic        SREQ;
  logic [NB:0] fifo_level;
  logic        underrun;
  logic        sample_tick;
  logic [15:0] audio_left;
  logic [15:0] audio_right;

  dma_snd_engine #(
    .FIFO_ADDR_BITS (NB),
    .BASE_DIV       (DIV),
    .SREQ_LEVEL     (2)
  ) dut (
    .clk32        (clk32),
    .res          (res),
    .enable       (enable),
    .mode         (mode),
    .SLOAD_N      (SLOAD_N),
    .MDIN         (MDIN),
    .clr_underrun (clr_underrun),
    .SREQ         (SREQ),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .sample_tick  (sample_tick),
    .audio_left   (audio_left),
    .audio_right  (audio_right)
  );

  always #5 clk32 = ~clk32;

  int cyc = 0;
  always @(posedge clk32) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_tick_cyc = 0;

  // ---------------------------------------------------------- reference model
  logic [15:0] q[$];
  bit          m_bsel;
  bit          m_und;
  logic [15:0] m_l, m_r;
  logic [1:0]  m_fmt;   // {16-bit, mono}

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_strobe();
    logic [15:0] h;
    logic [7:0]  b;
    int need;
    need = (m_fmt == 2'b10) ? 2 : 1;
    if (q.size() < need) begin
      m_und = 1'b1;
    end else begin
      h = q[0];
      case (m_fmt)
        2'b00: begin m_l = {h[15:8], 8'h00}; m_r = {h[7:0], 8'h00}; void'(q.pop_front()); end
        2'b01: begin
          b = m_bsel ? h[7:0] : h[15:8];
          m_l = {b, 8'h00}; m_r = {b, 8'h00};
          if (m_bsel) void'(q.pop_front());
          m_bsel = ~m_bsel;
        end
        2'b10: begin m_l = h; m_r = q[1]; void'(q.pop_front()); void'(q.pop_front()); end
        default: begin m_l = h; m_r = h; void'(q.pop_front()); end
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_left"},  {16'h0, audio_left},  {16'h0, m_l});
    chk({tag, "_right"}, {16'h0, audio_right}, {16'h0, m_r});
    chk({tag, "_level"}, {28'h0, fifo_level},  q.size());
    chk({tag, "_underrun"}, {31'h0, underrun}, {31'h0, m_und});
  endtask

  // ------------------------------------------------------------ drive tasks
  task automatic push(input logic [15:0] w);
    SLOAD_N = 1'b0;
    MDIN    = w;
    @(negedge clk32);
    SLOAD_N = 1'b1;
    @(negedge clk32);
    @(negedge clk32);
    if (enable && q.size() < 8) q.push_back(w);
  endtask

  task automatic flush();
    enable = 1'b0;
    @(negedge clk32);
    enable = 1'b1;
    q.delete();
    m_bsel = 0; m_l = '0; m_r = '0;
  endtask

  task automatic setmode(input logic [3:0] m);
    mode = m;
    if (m[3:2] != m_fmt) m_bsel = 0;
    m_fmt = m[3:2];
    @(negedge clk32);
  endtask

  task automatic clr();
    clr_underrun = 1'b1;
    @(negedge clk32);
    clr_underrun = 1'b0;
    m_und = 0;
  endtask

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    @(negedge clk32);
    while (!sample_tick && n < budget) begin
      @(negedge clk32);
      n++;
    end
    if (!sample_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no sample_tick within %0d cycles", budget);
    end
    last_tick_cyc = cyc;
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct packed {
    logic [3:0]        mode;
    logic [1:0]        nw;
    logic [1:0][15:0]  w;
    logic [1:0]        nstr;
    logic [1:0][15:0]  el;
    logic [1:0][15:0]  er;
    logic [1:0][3:0]   elv;
    logic              esreq;
    logic              chk_period;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] md, input int nw,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input int ns,
                              input logic [15:0] l0, input logic [15:0] r0, input int v0,
                              input logic [15:0] l1, input logic [15:0] r1, input int v1,
                              input bit sr, input bit cp);
    vec_t v;
    v.mode = md; v.nw = 2'(nw); v.w[0] = w0; v.w[1] = w1; v.nstr = 2'(ns);
    v.el[0] = l0; v.er[0] = r0; v.elv[0] = 4'(v0);
    v.el[1] = l1; v.er[1] = r1; v.elv[1] = 4'(v1);
    v.esreq = sr; v.chk_period = cp;
    return v;
  endfunction

  vec_t tbl[4];

  initial begin
    logic [3:0] md;
    int t0;

    tbl[0] = mk(4'b0011, 2, 16'h7F80, 16'h0102, 2, 16'h7F00, 16'h8000, 1, 16'h0100, 16'h0200, 0, 1, 1);
    tbl[1] = mk(4'b0111, 1, 16'h1234, 16'h0000, 2, 16'h1200, 16'h1200, 1, 16'h3400, 16'h3400, 0, 1, 0);
    tbl[2] = mk(4'b1011, 2, 16'h8001, 16'h7FFE, 1, 16'h8001, 16'h7FFE, 0, 16'h0000, 16'h0000, 0, 1, 0);
    tbl[3] = mk(4'b1111, 2, 16'hA5A5, 16'h5A5A, 2, 16'hA5A5, 16'hA5A5, 1, 16'h5A5A, 16'h5A5A, 0, 1, 0);

    res = 1'b1; enable = 1'b1; mode = 4'b0011; SLOAD_N = 1'b1; MDIN = '0; clr_underrun = 1'b0;
    q.delete(); m_bsel = 0; m_und = 0; m_l = '0; m_r = '0; m_fmt = 2'b00;

    // Reset state (enable high: SREQ must still be held low by reset)
    repeat (3) @(negedge clk32);
    chk("rst_sreq",   {31'h0, SREQ}, 0);
    chk("rst_level",  {28'h0, fifo_level}, 0);
    chk("rst_underrun", {31'h0, underrun}, 0);
    chk("rst_tick",   {31'h0, sample_tick}, 0);
    chk("rst_left",   {16'h0, audio_left}, 0);
    chk("rst_right",  {16'h0, audio_right}, 0);
    res = 1'b0;

    // Format table
    for (int i = 0; i < 4; i++) begin
      wait_tick(3000);
      flush();
      setmode(tbl[i].mode);
      clr();
      for (int k = 0; k < int'(tbl[i].nw); k++) push(tbl[i].w[k]);
      chk($sformatf("tbl%0d_fill_level", i), {28'h0, fifo_level}, {30'h0, tbl[i].nw});
      chk($sformatf("tbl%0d_sreq", i), {31'h0, SREQ}, {31'h0, tbl[i].esreq});
      t0 = 0;
      for (int s = 0; s < int'(tbl[i].nstr); s++) begin
        wait_tick(3000);
        chk($sformatf("tbl%0d_s%0d_left", i, s),  {16'h0, audio_left},  {16'h0, tbl[i].el[s]});
        chk($sformatf("tbl%0d_s%0d_right", i, s), {16'h0, audio_right}, {16'h0, tbl[i].er[s]});
        chk($sformatf("tbl%0d_s%0d_level", i, s), {28'h0, fifo_level},  {28'h0, tbl[i].elv[s]});
        chk($sformatf("tbl%0d_s%0d_underrun", i, s), {31'h0, underrun}, 0);
        if (s == 1 && tbl[i].chk_period) chk("tick_period_50k", last_tick_cyc - t0, DIV);
        t0 = last_tick_cyc;
      end
    end

    // 16-bit stereo starvation
    wait_tick(3000);
    flush();
    setmode(4'b1011);
    clr();
    push(16'h1111);
    wait_tick(3000);
    chk("starve_underrun", {31'h0, underrun}, 1);
    chk("starve_left",  {16'h0, audio_left}, 0);
    chk("starve_right", {16'h0, audio_right}, 0);
    chk("starve_level", {28'h0, fifo_level}, 1);
    push(16'h2222);
    wait_tick(3000);
    chk("refill_left",  {16'h0, audio_left}, 16'h1111);
    chk("refill_right", {16'h0, audio_right}, 16'h2222);
    chk("refill_level", {28'h0, fifo_level}, 0);
    chk("underrun_sticky", {31'h0, underrun}, 1);
    clr();
    chk("underrun_cleared", {31'h0, underrun}, 0);

    // Set and clear on the same cycle: set wins
    setmode(4'b0011);
    clr_underrun = 1'b1;
    wait_tick(3000);
    chk("set_beats_clear", {31'h0, underrun}, 1);
    @(negedge clk32);
    chk("clear_after_set", {31'h0, underrun}, 0);
    clr_underrun = 1'b0;

    // Full FIFO and watermark
    wait_tick(3000);
    flush();
    clr();
    for (int k = 0; k < 6; k++) push(16'h1000 + 16'(k));
    chk("wm_sreq_at6", {31'h0, SREQ}, 1);
    push(16'h1006);
    chk("wm_sreq_at7", {31'h0, SREQ}, 0);
    chk("wm_level7", {28'h0, fifo_level}, 7);
    push(16'h1007);
    chk("full_level8", {28'h0, fifo_level}, 8);
    push(16'hDEAD);
    chk("full_drop_level", {28'h0, fifo_level}, 8);

    // Write landing on the same edge as a pop while full
    while (cyc != last_tick_cyc + DIV - 2) @(negedge clk32);
    SLOAD_N = 1'b0; MDIN = 16'hBEEF;
    @(negedge clk32);
    SLOAD_N = 1'b1;
    @(negedge clk32);
    chk("simul_tick", {31'h0, sample_tick}, 1);
    chk("simul_level", {28'h0, fifo_level}, 8);
    chk("simul_left",  {16'h0, audio_left}, 16'h1000);
    chk("simul_right", {16'h0, audio_right}, 16'h0000);
    enable = 1'b0;
    @(negedge clk32);
    chk("dis_level", {28'h0, fifo_level}, 0);
    chk("dis_left",  {16'h0, audio_left}, 0);
    chk("dis_right", {16'h0, audio_right}, 0);
    chk("dis_sreq",  {31'h0, SREQ}, 0);
    enable = 1'b1;

    // Randomised playback against the model
    wait_tick(3000);
    flush();
    setmode(4'b0011);
    clr();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        md = 4'($urandom_range(0, 3) << 2) | 4'b0011;
        setmode(md);
      end
      for (int k = $urandom_range(0, 3); k > 0; k--) push(16'($urandom));
      if ($urandom_range(0, 3) == 0) clr();
      wait_tick(3000);
      m_strobe();
      check_model($sformatf("rnd%0d", it));
    end

    // Reset mid-playback
    wait_tick(3000);
    flush();
    setmode(4'b0011);
    clr();
    wait_tick(3000);
    push(16'h4321);
    push(16'h5678);
    wait_tick(3000);
    chk("pre_rst_left", {16'h0, audio_left}, 16'h4300);
    @(posedge clk32);
    #3 res = 1'b1;
    #1;
    chk("arst_left",  {16'h0, audio_left}, 0);
    chk("arst_right", {16'h0, audio_right}, 0);
    chk("arst_level", {28'h0, fifo_level}, 0);
    chk("arst_underrun", {31'h0, underrun}, 0);
    chk("arst_sreq",  {31'h0, SREQ}, 0);
    @(negedge clk32);
    res = 1'b0;
    wait_tick(3000);
    chk("post_rst_underrun", {31'h0, underrun}, 1);
    chk("post_rst_level", {28'h0, fifo_level}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
